hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the five-stage RV32I core. It takes stage hazard status, memory handshakes and the EX-stage branch outcome, and drives the per-stage pipeline-register load enables, the bubble/flush controls and PC source selection. It complements the operand forwarding unit by stalling for the load-use case that forwarding cannot cover. It also handles branch redirects that arrive while an instruction fetch is still outstanding, and keeps stall and flush counters for performance debug.

## Interface
- `width`, 32: width of each performance counter.

- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-low reset
- `IF_ID_rs1_i`, `IF_ID_rs2_i`  in  rv32i_reg  source registers of the instruction in ID
- `ID_EX_rd_i`  in  rv32i_reg  destination of the instruction in EX
- `ID_EX_mem_read_i`  in  1  instruction in EX is a load
- `EX_br_taken_i`  in  1  branch/jump in EX resolved taken (target valid this cycle)
- `imem_resp_i`  in  1  fetch for the current PC completes this cycle
- `dmem_req_i`  in  1  MEM stage has a load/store outstanding
- `dmem_resp_i`  in  1  data access completes this cycle
- `load_pc_o`, `load_if_id_o`, `load_id_ex_o`, `load_ex_mem_o`, `load_mem_wb_o`  out  1  stage register load enables
- `bubble_id_ex_o`  out  1  ID/EX loads a NOP instead of ID contents
- `flush_if_id_o`  out  1  IF/ID loads a NOP
- `pc_src_o`  out  pcsrc_sel_t  PC mux select: `pc_plus4`, `ex_target`, `saved_target`
- `save_target_o`  out  1  datapath captures the EX branch target into its saved-target register
- `stall_cycles_o`  out  width  cycles with `load_pc_o`=0
- `redirect_count_o`  out  width  redirects applied

## Operation
- States: `RUN`, `REDIRECT_WAIT`. Reset state is `RUN`.
- `dstall` = `dmem_req_i` & ~`dmem_resp_i`. `istall` = ~`imem_resp_i`.
- `lu_hazard` = `ID_EX_mem_read_i` & |`ID_EX_rd_i` & (`ID_EX_rd_i` == `IF_ID_rs1_i` | `ID_EX_rd_i` == `IF_ID_rs2_i`).
- Priority, evaluated every cycle:
  1. `dstall` freezes every stage: all loads are 0, no flush, no bubble, and no state change. The branch in EX is evaluated again once the freeze lifts.
  2. `EX_br_taken_i` in `RUN`:
     - If ~`istall`: `pc_src`=`ex_target`, `flush_if_id`=1, `bubble_id_ex`=1, all loads 1, `redirect_count`+1.
     - If `istall`: the PC must hold because the fetch is outstanding. Assert `save_target`=1, `bubble_id_ex`=1, EX/MEM and MEM/WB load, PC and IF/ID hold, and go to `REDIRECT_WAIT`.
  3. In `REDIRECT_WAIT`:
     - Hold PC and IF/ID, bubble ID/EX, back end advances.
     - On `imem_resp_i`: `pc_src`=`saved_target`, load PC, `flush_if_id`=1 (discard the wrong-path fetch), `redirect_count`+1, return to `RUN`.
     - `EX_br_taken_i` is ignored here because EX holds only a bubble.
  4. `istall` in `RUN` (no branch): hold PC and IF/ID, bubble ID/EX, back end advances.
  5. `lu_hazard`: hold PC and IF/ID, bubble ID/EX for exactly one cycle. The load then sits in MEM and forwarding covers it.
  6. Otherwise: all loads 1, `pc_src`=`pc_plus4`.
- Branch taken overrides load-use, because the dependent instruction is wrong-path.
- `rd` = x0 never causes a stall.
- Counters are unsigned, wrap modulo 2^width, and do not saturate.

## Timing
- All controls are combinational from inputs and state, valid in the same cycle. State and counters update on the `clk` rising edge.
- While `rst`=0, asynchronously:
  - all load enables, `flush_if_id_o`, `bubble_id_ex_o` and `save_target_o` are 0
  - `pc_src_o` is `pc_plus4`
  - counters are 0
  - state is `RUN`
- Reset asserted mid-`REDIRECT_WAIT` abandons the saved redirect.
- `save_target_o` is asserted for exactly one cycle per deferred redirect.
- A deferred redirect takes at least 2 cycles from the taken branch to the target PC load.
- `dstall` during `REDIRECT_WAIT` holds the state, even if `imem_resp_i` is 1 that cycle. The instruction fetch side must keep its response until it is accepted.

## Structure
- `pcsrc::pcsrc_sel_t` (`pc_plus4`, `ex_target`, `saved_target`) and the state enum go in the shared `rv32i_types` package, alongside the forwarding mux enum.
- Sub-module `perf_counter` (parameter `width`; ports: `clk`, `rst`, `inc_i`, `count_o`) is instantiated twice.

## Test plan
- Load-use: EX holds `lw x5` (rd=5, mem_read=1) and ID reads rs1=5. Expect exactly 1 cycle of load_pc=0, load_if_id=0, bubble_id_ex=1, then all loads 1. `stall_cycles`=1.
- x0 case: same as load-use but rd=0. Expect no stall.
- Taken branch with `imem_resp`=1: expect `pc_src`=`ex_target`, `flush_if_id`=1, `bubble_id_ex`=1, and `redirect_count` 0→1 on the next edge.
- Deferred redirect: branch taken while `imem_resp`=0 for 3 cycles. Expect `save_target`=1 in cycle 0, `REDIRECT_WAIT` during cycles 1–3, then on the response `pc_src`=`saved_target` and `flush_if_id`=1. `stall_cycles` increases by 4.
- Data stall: `dmem_req`=1 and `dmem_resp`=0 for 5 cycles while a taken branch sits in EX. Expect all loads 0 for 5 cycles and the redirect applied on cycle 6.
- Reset: drop `rst` while in `REDIRECT_WAIT` with counters at 7 and 2. Expect immediate reset values. After release, the next `imem_resp` causes no redirect.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register index, PC mux select, forwarding select
// and the hazard controller state.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [1:0] {
    pc_plus4     = 2'b00,
    ex_target    = 2'b01,
    saved_target = 2'b10
  } pcsrc_sel_t;

  typedef enum logic [1:0] {
    fwd_none   = 2'b00,
    fwd_ex_mem = 2'b01,
    fwd_mem_wb = 2'b10
  } fwdsel_t;

  typedef enum logic {
    RUN           = 1'b0,
    REDIRECT_WAIT = 1'b1
  } hazard_state_t;

  // A load in EX feeding the instruction in ID; x0 is hardwired and never stalls.
  function automatic logic loadUseHazard(input logic memRead, input rv32i_reg exRd,
                                         input rv32i_reg idRs1, input rv32i_reg idRs2);
    return memRead && (exRd != 5'd0) && ((exRd == idRs1) || (exRd == idRs2));
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter for performance debug; clears asynchronously on reset.
module perf_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [width-1:0] count_o
);

  logic [width-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + {{(width-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline sequencer: load-use stalls, memory freezes and branch
// redirects, including redirects deferred behind an outstanding fetch.
module hazard_controller
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  rv32i_reg         IF_ID_rs1_i,
  input  rv32i_reg         IF_ID_rs2_i,
  input  rv32i_reg         ID_EX_rd_i,
  input  logic             ID_EX_mem_read_i,
  input  logic             EX_br_taken_i,
  input  logic             imem_resp_i,
  input  logic             dmem_req_i,
  input  logic             dmem_resp_i,
  output logic             load_pc_o,
  output logic             load_if_id_o,
  output logic             load_id_ex_o,
  output logic             load_ex_mem_o,
  output logic             load_mem_wb_o,
  output logic             bubble_id_ex_o,
  output logic             flush_if_id_o,
  output pcsrc_sel_t       pc_src_o,
  output logic             save_target_o,
  output logic [width-1:0] stall_cycles_o,
  output logic [width-1:0] redirect_count_o
);

  hazard_state_t state_q, state_d;
  logic dStall, iStall, luHazard, redirectInc, stallInc;

  assign dStall   = dmem_req_i & ~dmem_resp_i;
  assign iStall   = ~imem_resp_i;
  assign luHazard = loadUseHazard(ID_EX_mem_read_i, ID_EX_rd_i, IF_ID_rs1_i, IF_ID_rs2_i);

  always_comb begin
    load_pc_o      = 1'b1;
    load_if_id_o   = 1'b1;
    load_id_ex_o   = 1'b1;
    load_ex_mem_o  = 1'b1;
    load_mem_wb_o  = 1'b1;
    bubble_id_ex_o = 1'b0;
    flush_if_id_o  = 1'b0;
    save_target_o  = 1'b0;
    pc_src_o       = pc_plus4;
    redirectInc    = 1'b0;
    state_d        = state_q;

    if (!rst || dStall) begin
      // Reset and data-side freeze both hold every stage and the state.
      load_pc_o     = 1'b0;
      load_if_id_o  = 1'b0;
      load_id_ex_o  = 1'b0;
      load_ex_mem_o = 1'b0;
      load_mem_wb_o = 1'b0;
    end else if (state_q == REDIRECT_WAIT) begin
      bubble_id_ex_o = 1'b1;
      if (imem_resp_i) begin
        pc_src_o      = saved_target;
        flush_if_id_o = 1'b1;
        redirectInc   = 1'b1;
        state_d       = RUN;
      end else begin
        load_pc_o    = 1'b0;
        load_if_id_o = 1'b0;
      end
    end else if (EX_br_taken_i) begin
      bubble_id_ex_o = 1'b1;
      if (!iStall) begin
        pc_src_o      = ex_target;
        flush_if_id_o = 1'b1;
        redirectInc   = 1'b1;
      end else begin
        // Fetch still outstanding: park the target and redirect when it returns.
        save_target_o = 1'b1;
        load_pc_o     = 1'b0;
        load_if_id_o  = 1'b0;
        state_d       = REDIRECT_WAIT;
      end
    end else if (iStall || luHazard) begin
      load_pc_o      = 1'b0;
      load_if_id_o   = 1'b0;
      bubble_id_ex_o = 1'b1;
    end
  end

  assign stallInc = ~load_pc_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  perf_counter #(.width(width)) uStallCounter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (stallInc),
    .count_o(stall_cycles_o)
  );

  perf_counter #(.width(width)) uRedirectCounter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (redirectInc),
    .count_o(redirect_count_o)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with literal
// expectations, then randomized traffic against a rule-level reference model.
module tb_hazard_controller;
  import rv32i_types::*;

  localparam int W = 32;
  // Control vector: {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble, flush, save, pc_src}
  localparam logic [9:0] CTL_NORMAL = 10'b11111_000_00;
  localparam logic [9:0] CTL_HOLD   = 10'b00111_100_00;
  localparam logic [9:0] CTL_REDIR  = 10'b11111_110_01;
  localparam logic [9:0] CTL_DEFER  = 10'b00111_101_00;
  localparam logic [9:0] CTL_WAIT   = 10'b00111_100_00;
  localparam logic [9:0] CTL_FINISH = 10'b11111_110_10;
  localparam logic [9:0] CTL_FREEZE = 10'b00000_000_00;

  typedef struct packed {
    logic [9:0] ctl;
    logic       nextWait;
    logic       redirect;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  rv32i_reg rs1, rs2, rd;
  logic memRead, brTaken, imemResp, dmemReq, dmemResp;
  logic loadPc, loadIfId, loadIdEx, loadExMem, loadMemWb, bubble, flush, saveTarget;
  pcsrc_sel_t pcSrc;
  logic [1:0] pcSrcBits;
  logic [W-1:0] stallCycles, redirectCount;
  logic [9:0] dutCtl;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_controller #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1_i(rs1), .IF_ID_rs2_i(rs2), .ID_EX_rd_i(rd),
    .ID_EX_mem_read_i(memRead), .EX_br_taken_i(brTaken),
    .imem_resp_i(imemResp), .dmem_req_i(dmemReq), .dmem_resp_i(dmemResp),
    .load_pc_o(loadPc), .load_if_id_o(loadIfId), .load_id_ex_o(loadIdEx),
    .load_ex_mem_o(loadExMem), .load_mem_wb_o(loadMemWb),
    .bubble_id_ex_o(bubble), .flush_if_id_o(flush), .pc_src_o(pcSrc),
    .save_target_o(saveTarget), .stall_cycles_o(stallCycles),
    .redirect_count_o(redirectCount)
  );

  assign pcSrcBits = pcSrc;
  assign dutCtl = {loadPc, loadIfId, loadIdEx, loadExMem, loadMemWb, bubble, flush, saveTarget, pcSrcBits};

  // Reference: apply the priority rules directly, with the deferred redirect as one flag.
  function automatic exp_t predict(input logic waiting, input rv32i_reg a, input rv32i_reg b,
                                   input rv32i_reg d, input logic mr, input logic br,
                                   input logic im, input logic dq, input logic dr);
    exp_t e;
    bit hazard;
    e.ctl = CTL_NORMAL;
    e.nextWait = waiting;
    e.redirect = 1'b0;
    hazard = mr && (d != 0) && (d == a || d == b);
    if (dq && !dr) e.ctl = CTL_FREEZE;
    else if (waiting) begin
      if (im) begin e.ctl = CTL_FINISH; e.nextWait = 1'b0; e.redirect = 1'b1; end
      else e.ctl = CTL_WAIT;
    end else if (br) begin
      if (im) begin e.ctl = CTL_REDIR; e.redirect = 1'b1; end
      else begin e.ctl = CTL_DEFER; e.nextWait = 1'b1; end
    end else if (!im || hazard) e.ctl = CTL_HOLD;
    return e;
  endfunction

  task automatic setInputs(input rv32i_reg a, input rv32i_reg b, input rv32i_reg d, input logic mr,
                           input logic br, input logic im, input logic dq, input logic dr);
    rs1 = a; rs2 = b; rd = d; memRead = mr;
    brTaken = br; imemResp = im; dmemReq = dq; dmemResp = dr;
  endtask

  task automatic drive(input rv32i_reg a, input rv32i_reg b, input rv32i_reg d, input logic mr,
                       input logic br, input logic im, input logic dq, input logic dr);
    @(posedge clk);
    #1;
    setInputs(a, b, d, mr, br, im, dq, dr);
    #2;
  endtask

  task automatic doReset;
    @(posedge clk);
    #1;
    rst = 1'b0;
    setInputs(0, 0, 0, 0, 0, 1, 0, 0);
    #4;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    rst = 1'b0;
    setInputs(1, 2, 3, 0, 0, 1, 0, 0);
    #2;
    total++; if (dutCtl !== CTL_FREEZE) begin bad++; $display("[TB] FAIL reset_ctl got=%b want=%b", dutCtl, CTL_FREEZE); end
    total++; if (stallCycles !== 0 || redirectCount !== 0) begin bad++; $display("[TB] FAIL reset_counters got=%0d/%0d want=0/0", stallCycles, redirectCount); end
    #2;
    rst = 1'b1;
    drive(1, 2, 3, 0, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_NORMAL) begin bad++; $display("[TB] FAIL post_reset_normal got=%b want=%b", dutCtl, CTL_NORMAL); end
  endtask

  task automatic test_load_use;
    doReset();
    drive(5, 0, 5, 1, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_HOLD) begin bad++; $display("[TB] FAIL loaduse_hold got=%b want=%b", dutCtl, CTL_HOLD); end
    drive(5, 0, 0, 0, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_NORMAL) begin bad++; $display("[TB] FAIL loaduse_release got=%b want=%b", dutCtl, CTL_NORMAL); end
    total++; if (stallCycles !== 32'd1) begin bad++; $display("[TB] FAIL loaduse_stalls got=%0d want=1", stallCycles); end
    drive(0, 7, 7, 1, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_HOLD) begin bad++; $display("[TB] FAIL loaduse_rs2 got=%b want=%b", dutCtl, CTL_HOLD); end
  endtask

  task automatic test_x0;
    doReset();
    drive(0, 0, 0, 1, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_NORMAL) begin bad++; $display("[TB] FAIL x0_nostall got=%b want=%b", dutCtl, CTL_NORMAL); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (stallCycles !== 32'd0) begin bad++; $display("[TB] FAIL x0_stalls got=%0d want=0", stallCycles); end
  endtask

  task automatic test_branch_taken;
    doReset();
    drive(5, 0, 5, 1, 1, 1, 0, 0);
    total++; if (dutCtl !== CTL_REDIR) begin bad++; $display("[TB] FAIL branch_redirect got=%b want=%b", dutCtl, CTL_REDIR); end
    total++; if (redirectCount !== 32'd0) begin bad++; $display("[TB] FAIL branch_count_before got=%0d want=0", redirectCount); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (redirectCount !== 32'd1) begin bad++; $display("[TB] FAIL branch_count_after got=%0d want=1", redirectCount); end
    total++; if (stallCycles !== 32'd0) begin bad++; $display("[TB] FAIL branch_stalls got=%0d want=0", stallCycles); end
  endtask

  task automatic test_deferred_redirect;
    doReset();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    total++; if (dutCtl !== CTL_DEFER) begin bad++; $display("[TB] FAIL defer_save got=%b want=%b", dutCtl, CTL_DEFER); end
    for (int c = 1; c <= 3; c++) begin
      drive(0, 0, 0, 0, (c == 2), 0, 0, 0);
      total++; if (dutCtl !== CTL_WAIT) begin bad++; $display("[TB] FAIL defer_wait%0d got=%b want=%b", c, dutCtl, CTL_WAIT); end
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_FINISH) begin bad++; $display("[TB] FAIL defer_finish got=%b want=%b", dutCtl, CTL_FINISH); end
    total++; if (stallCycles !== 32'd4) begin bad++; $display("[TB] FAIL defer_stalls got=%0d want=4", stallCycles); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_NORMAL || redirectCount !== 32'd1) begin bad++; $display("[TB] FAIL defer_done ctl=%b cnt=%0d want=%b/1", dutCtl, redirectCount, CTL_NORMAL); end
  endtask

  task automatic test_data_stall;
    doReset();
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 1, 1, 1, 0);
      total++; if (dutCtl !== CTL_FREEZE) begin bad++; $display("[TB] FAIL dstall_freeze%0d got=%b want=%b", c, dutCtl, CTL_FREEZE); end
    end
    drive(0, 0, 0, 0, 1, 1, 1, 1);
    total++; if (dutCtl !== CTL_REDIR) begin bad++; $display("[TB] FAIL dstall_redirect got=%b want=%b", dutCtl, CTL_REDIR); end
    total++; if (stallCycles !== 32'd5) begin bad++; $display("[TB] FAIL dstall_stalls got=%0d want=5", stallCycles); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (redirectCount !== 32'd1) begin bad++; $display("[TB] FAIL dstall_count got=%0d want=1", redirectCount); end
    // Freeze inside the deferred window must hold even with the fetch response present.
    doReset();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    total++; if (dutCtl !== CTL_FREEZE) begin bad++; $display("[TB] FAIL wait_freeze got=%b want=%b", dutCtl, CTL_FREEZE); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_FINISH) begin bad++; $display("[TB] FAIL wait_freeze_finish got=%b want=%b", dutCtl, CTL_FINISH); end
  endtask

  task automatic test_reset_mid_wait;
    doReset();
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    for (int c = 0; c < 5; c++) drive(5, 0, 5, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (dutCtl !== CTL_WAIT || stallCycles !== 32'd7 || redirectCount !== 32'd2) begin bad++; $display("[TB] FAIL midwait_setup ctl=%b cnt=%0d/%0d want=%b 7/2", dutCtl, stallCycles, redirectCount, CTL_WAIT); end
    #1;
    rst = 1'b0;
    #1;
    total++; if (dutCtl !== CTL_FREEZE || stallCycles !== 0 || redirectCount !== 0) begin bad++; $display("[TB] FAIL midwait_reset ctl=%b cnt=%0d/%0d want=0 0/0", dutCtl, stallCycles, redirectCount); end
    #3;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (dutCtl !== CTL_NORMAL) begin bad++; $display("[TB] FAIL midwait_abandon got=%b want=%b", dutCtl, CTL_NORMAL); end
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (redirectCount !== 32'd0) begin bad++; $display("[TB] FAIL midwait_count got=%0d want=0", redirectCount); end
  endtask

  task automatic test_random;
    exp_t e, prev;
    logic mWait, prevRst;
    logic [W-1:0] mStall, mRedir;
    rv32i_reg a, b, d;
    logic mr, br, im, dq, dr;
    doReset();
    mWait = 1'b0; mStall = '0; mRedir = '0; prevRst = 1'b0;
    prev = '0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (prevRst) begin
        if (!prev.ctl[9]) mStall = mStall + 1;
        if (prev.redirect) mRedir = mRedir + 1;
        mWait = prev.nextWait;
      end
      rst = ($urandom_range(0, 99) != 0);
      a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); d = 5'($urandom_range(0, 3));
      mr = ($urandom_range(0, 1) == 1);
      br = ($urandom_range(0, 3) == 0);
      im = ($urandom_range(0, 9) < 7);
      dq = ($urandom_range(0, 9) < 3);
      dr = ($urandom_range(0, 1) == 1);
      setInputs(a, b, d, mr, br, im, dq, dr);
      if (!rst) begin
        mWait = 1'b0; mStall = '0; mRedir = '0;
        e = '0;
      end else begin
        e = predict(mWait, a, b, d, mr, br, im, dq, dr);
      end
      #2;
      total++; if (dutCtl !== e.ctl) begin bad++; $display("[TB] FAIL rand_ctl[%0d] got=%b want=%b", i, dutCtl, e.ctl); end
      total++; if (stallCycles !== mStall || redirectCount !== mRedir) begin bad++; $display("[TB] FAIL rand_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, stallCycles, redirectCount, mStall, mRedir); end
      prev = e;
      prevRst = rst;
    end
  endtask

  initial begin
    rst = 1'b0;
    setInputs(0, 0, 0, 0, 0, 1, 0, 0);
    test_reset();
    test_load_use();
    test_x0();
    test_branch_taken();
    test_deferred_redirect();
    test_data_stall();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
